decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/immediate width.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 5: width of the emitted ALU opcode.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: instr and pc are valid.
REQ-006 SHALL have port in_ready, output, 1: stage accepts an instruction this cycle.
REQ-007 SHALL have port instr, input, 32: RV32I instruction word.
REQ-008 SHALL have port pc, input, DATA_WIDTH: address of instr.
REQ-009 SHALL have port flush, input, 1: discard the registered instruction (branch redirect).
REQ-010 SHALL have port out_valid, output, 1: registered decode result valid.
REQ-011 SHALL have port out_ready, input, 1: execute stage consumes the result.
REQ-012 SHALL have port alu_op, output, OPCODE_LENGTH: ALU opcode, encoding per REQ-020.
REQ-013 SHALL have ports rs1_idx, rs2_idx, rd_idx, output, 5 each: register indices.
REQ-014 SHALL have port imm, output, DATA_WIDTH: immediate per REQ-021.
REQ-015 SHALL have ports use_imm, use_pc, rd_we, is_branch, output, 1 each: operand-B select, operand-A = pc, writeback enable, branch flag.
REQ-016 SHALL have port out_pc, output, DATA_WIDTH: registered pc.
REQ-017 SHALL have port illegal, output, 1: registered instruction is undecodable.
REQ-018 SHALL have port illegal_cnt, output, 8: saturating count of accepted illegal instructions.

Function
REQ-019 SHALL be a single pipeline register: in_ready = !out_valid || out_ready; transfer when in_valid && in_ready; latency 1 cycle.
REQ-020 SHALL encode alu_op: ADD 1, SUB 2, SLL 3, SRL 4, SRA 5, AND 6, OR 7, XOR 8, SLT 9, SLTU 10, ADDI 11, SLLI 12, SRLI 13, SRAI 14, ANDI 15, ORI 16, SLTI 17, SLTIU 18, LUI 19, AUIPC 20; 0 = NOP.
REQ-021 SHALL emit I-type imm as instr[31:20] zero-padded to DATA_WIDTH (sign extension done by ALU); shift-immediates as instr[24:20]; LUI/AUIPC as {instr[31:12],12'b0}; B-type as sign-extended branch offset.
REQ-022 SHALL decode XORI as alu_op 8 with use_imm=1 and imm fully sign-extended from instr[31].
REQ-023 SHALL decode BEQ/BNE/BLT/BGE as alu_op 2, is_branch=1, rd_we=0; AUIPC with use_pc=1.
REQ-024 SHALL flag illegal=1, alu_op=0, rd_we=0 for unsupported opcode, bad funct3/funct7, or SRAI/SRLI funct7 mismatch.
REQ-025 SHALL force rd_we=0 when rd_idx=0.
REQ-026 SHALL, on flush, clear out_valid next cycle and drop any simultaneous in_valid transfer; flush has priority over accept.
REQ-027 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-028 SHALL increment illegal_cnt once per accepted illegal instruction, saturating at 255; flushed instructions still count.

Reset
REQ-029 SHALL, on reset, set out_valid=0, illegal=0, illegal_cnt=0, alu_op=0, all other outputs 0; reset overrides flush and in_valid.
REQ-030 SHALL drive in_ready=1 in the cycle after reset deasserts.

Structure
REQ-031 SHALL take alu_op encodings and RV32I opcode/funct constants from shared package core_pkg, also used by the ALU.
REQ-032 SHALL place combinational decode in sub-module instr_decoder; decode_stage holds handshake and registers.

Verification
REQ-033 SHALL test: ADD x3,x1,x2 (0x002081B3) accepted -> next cycle out_valid=1, alu_op=1, rs1=1, rs2=2, rd=3, rd_we=1.
REQ-034 SHALL test: ADDI x5,x0,-1 (0xFFF00293) -> alu_op=11, imm=0x00000FFF, use_imm=1; XORI x5,x5,-1 -> alu_op=8, imm=0xFFFFFFFF.
REQ-035 SHALL test: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> next instr loaded next cycle.
REQ-036 SHALL test: flush and in_valid same cycle -> out_valid=0 next cycle, no instruction lost beyond the flushed one.
REQ-037 SHALL test: 300 accepted 0x00000000 words -> illegal=1 each, illegal_cnt stops at 255; reset -> 0.
REQ-038 SHALL test: LUI x1,0x12345 (0x123450B7) -> alu_op=19, imm=0x12345000; AUIPC -> alu_op=20, use_pc=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: ALU opcode encoding and the RV32I opcode/funct
// fields recognised by the decode stage and the ALU.
package core_pkg;

    typedef enum logic [4:0] {
        ALU_NOP   = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_SLL   = 5'd3,
        ALU_SRL   = 5'd4,
        ALU_SRA   = 5'd5,
        ALU_AND   = 5'd6,
        ALU_OR    = 5'd7,
        ALU_XOR   = 5'd8,
        ALU_SLT   = 5'd9,
        ALU_SLTU  = 5'd10,
        ALU_ADDI  = 5'd11,
        ALU_SLLI  = 5'd12,
        ALU_SRLI  = 5'd13,
        ALU_SRAI  = 5'd14,
        ALU_ANDI  = 5'd15,
        ALU_ORI   = 5'd16,
        ALU_SLTI  = 5'd17,
        ALU_SLTIU = 5'd18,
        ALU_LUI   = 5'd19,
        ALU_AUIPC = 5'd20
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I decoder (OP, OP-IMM, LUI, AUIPC, BEQ/BNE/BLT/BGE).
import core_pkg::*;

module instr_decoder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    output alu_op_e               alu_op,
    output logic [4:0]            rs1_idx,
    output logic [4:0]            rs2_idx,
    output logic [4:0]            rd_idx,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  use_imm,
    output logic                  use_pc,
    output logic                  rd_we,
    output logic                  is_branch,
    output logic                  illegal
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       writes_rd;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign rd_idx  = instr[11:7];

    // I-type immediates are left zero-padded; the ALU sign-extends them, XORI excepted.
    logic [DATA_WIDTH-1:0] i_imm_zext, i_imm_sext, shamt_imm, u_imm, b_imm;
    assign i_imm_zext = DATA_WIDTH'(instr[31:20]);
    assign i_imm_sext = DATA_WIDTH'($signed(instr[31:20]));
    assign shamt_imm  = DATA_WIDTH'(instr[24:20]);
    assign u_imm      = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
    assign b_imm      = DATA_WIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));

    always_comb begin
        alu_op    = ALU_NOP;
        imm       = '0;
        use_imm   = 1'b0;
        use_pc    = 1'b0;
        is_branch = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                writes_rd = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: alu_op = ALU_ADD;
                        F3_SLL:     alu_op = ALU_SLL;
                        F3_SLT:     alu_op = ALU_SLT;
                        F3_SLTU:    alu_op = ALU_SLTU;
                        F3_XOR:     alu_op = ALU_XOR;
                        F3_SRL_SRA: alu_op = ALU_SRL;
                        F3_OR:      alu_op = ALU_OR;
                        default:    alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    alu_op = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                writes_rd = 1'b1;
                use_imm   = 1'b1;
                imm       = i_imm_zext;
                case (funct3)
                    F3_ADD_SUB: alu_op = ALU_ADDI;
                    F3_SLT:     alu_op = ALU_SLTI;
                    F3_SLTU:    alu_op = ALU_SLTIU;
                    F3_OR:      alu_op = ALU_ORI;
                    F3_AND:     alu_op = ALU_ANDI;
                    F3_XOR: begin
                        alu_op = ALU_XOR;
                        imm    = i_imm_sext;
                    end
                    F3_SLL: begin
                        imm = shamt_imm;
                        if (funct7 == F7_BASE) alu_op = ALU_SLLI;
                        else illegal = 1'b1;
                    end
                    default: begin
                        imm = shamt_imm;
                        if (funct7 == F7_BASE) alu_op = ALU_SRLI;
                        else if (funct7 == F7_ALT) alu_op = ALU_SRAI;
                        else illegal = 1'b1;
                    end
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1;
                use_imm   = 1'b1;
                imm       = u_imm;
                use_pc    = (opcode == OPC_AUIPC);
                alu_op    = (opcode == OPC_AUIPC) ? ALU_AUIPC : ALU_LUI;
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                imm       = b_imm;
                case (funct3)
                    F3_BEQ, F3_BNE, F3_BLT, F3_BGE: alu_op = ALU_SUB;
                    default:                        illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            alu_op    = ALU_NOP;
            imm       = '0;
            use_imm   = 1'b0;
            use_pc    = 1'b0;
            is_branch = 1'b0;
            writes_rd = 1'b0;
        end
    end

    assign rd_we = writes_rd && (rd_idx != 5'd0);

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline register: valid/ready handshake around instr_decoder, with
// branch flush and a saturating count of accepted illegal instructions.
import core_pkg::*;

module decode_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    output logic [4:0]               rs1_idx,
    output logic [4:0]               rs2_idx,
    output logic [4:0]               rd_idx,
    output logic [DATA_WIDTH-1:0]    imm,
    output logic                     use_imm,
    output logic                     use_pc,
    output logic                     rd_we,
    output logic                     is_branch,
    output logic [DATA_WIDTH-1:0]    out_pc,
    output logic                     illegal,
    output logic [7:0]               illegal_cnt
);
    alu_op_e               dec_alu_op;
    logic [4:0]            dec_rs1, dec_rs2, dec_rd;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic                  dec_use_imm, dec_use_pc, dec_rd_we, dec_is_branch, dec_illegal;

    instr_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_decoder (
        .instr     (instr),
        .alu_op    (dec_alu_op),
        .rs1_idx   (dec_rs1),
        .rs2_idx   (dec_rs2),
        .rd_idx    (dec_rd),
        .imm       (dec_imm),
        .use_imm   (dec_use_imm),
        .use_pc    (dec_use_pc),
        .rd_we     (dec_rd_we),
        .is_branch (dec_is_branch),
        .illegal   (dec_illegal)
    );

    logic                     out_valid_reg;
    logic [OPCODE_LENGTH-1:0] alu_op_reg;
    logic [4:0]               rs1_reg, rs2_reg, rd_reg;
    logic [DATA_WIDTH-1:0]    imm_reg, pc_reg;
    logic                     use_imm_reg, use_pc_reg, rd_we_reg, is_branch_reg, illegal_reg;
    logic [7:0]               illegal_cnt_reg, illegal_cnt_next;
    logic                     accept;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // An instruction dropped by a coincident flush was still handed over, so it counts.
    assign illegal_cnt_next = (accept && dec_illegal && illegal_cnt_reg != 8'hFF)
                              ? illegal_cnt_reg + 8'd1 : illegal_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg   <= 1'b0;
            alu_op_reg      <= '0;
            rs1_reg         <= '0;
            rs2_reg         <= '0;
            rd_reg          <= '0;
            imm_reg         <= '0;
            pc_reg          <= '0;
            use_imm_reg     <= 1'b0;
            use_pc_reg      <= 1'b0;
            rd_we_reg       <= 1'b0;
            is_branch_reg   <= 1'b0;
            illegal_reg     <= 1'b0;
            illegal_cnt_reg <= '0;
        end else begin
            illegal_cnt_reg <= illegal_cnt_next;
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (accept) begin
                out_valid_reg <= 1'b1;
                alu_op_reg    <= OPCODE_LENGTH'(dec_alu_op);
                rs1_reg       <= dec_rs1;
                rs2_reg       <= dec_rs2;
                rd_reg        <= dec_rd;
                imm_reg       <= dec_imm;
                pc_reg        <= pc;
                use_imm_reg   <= dec_use_imm;
                use_pc_reg    <= dec_use_pc;
                rd_we_reg     <= dec_rd_we;
                is_branch_reg <= dec_is_branch;
                illegal_reg   <= dec_illegal;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign alu_op      = alu_op_reg;
    assign rs1_idx     = rs1_reg;
    assign rs2_idx     = rs2_reg;
    assign rd_idx      = rd_reg;
    assign imm         = imm_reg;
    assign out_pc      = pc_reg;
    assign use_imm     = use_imm_reg;
    assign use_pc      = use_pc_reg;
    assign rd_we       = rd_we_reg;
    assign is_branch   = is_branch_reg;
    assign illegal     = illegal_reg;
    assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases plus random traffic checked
// against a mnemonic-level reference decoder.
module tb_decode_stage;
    localparam int DW = 32;
    localparam int OL = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   instr = '0;
    logic [DW-1:0] pc = '0;
    logic          in_ready, out_valid, use_imm, use_pc, rd_we, is_branch, illegal;
    logic [OL-1:0] alu_op;
    logic [4:0]    rs1_idx, rs2_idx, rd_idx;
    logic [DW-1:0] imm, out_pc;
    logic [7:0]    illegal_cnt;

    always #5 clk = ~clk;

    decode_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_op(alu_op), .rs1_idx(rs1_idx),
        .rs2_idx(rs2_idx), .rd_idx(rd_idx), .imm(imm), .use_imm(use_imm),
        .use_pc(use_pc), .rd_we(rd_we), .is_branch(is_branch), .out_pc(out_pc),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        use_imm, use_pc, rd_we, is_branch, illegal;
        logic        chk_rs1, chk_rs2, chk_rd, chk_imm;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         model_cnt = 0;
    int         txn = 0;
    bit         mon_en = 1'b0;
    int         op_of[string];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endfunction

    function automatic string mnemonic(logic [31:0] w);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'h33: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: return "ADD";
                        3'd1: return "SLL";
                        3'd2: return "SLT";
                        3'd3: return "SLTU";
                        3'd4: return "XOR";
                        3'd5: return "SRL";
                        3'd6: return "OR";
                        default: return "AND";
                    endcase
                end
                if (f7 == 7'h20 && f3 == 3'd0) return "SUB";
                if (f7 == 7'h20 && f3 == 3'd5) return "SRA";
                return "";
            end
            7'h13: begin
                case (f3)
                    3'd0: return "ADDI";
                    3'd1: return (f7 == 7'h00) ? "SLLI" : "";
                    3'd2: return "SLTI";
                    3'd3: return "SLTIU";
                    3'd4: return "XORI";
                    3'd5: return (f7 == 7'h00) ? "SRLI" : ((f7 == 7'h20) ? "SRAI" : "");
                    3'd6: return "ORI";
                    default: return "ANDI";
                endcase
            end
            7'h37: return "LUI";
            7'h17: return "AUIPC";
            7'h63: begin
                case (f3)
                    3'd0: return "BEQ";
                    3'd1: return "BNE";
                    3'd4: return "BLT";
                    3'd5: return "BGE";
                    default: return "";
                endcase
            end
            default: return "";
        endcase
    endfunction

    function automatic exp_t ref_decode(logic [31:0] w, logic [31:0] p);
        exp_t  e;
        string m;
        int    off;
        e     = '0;
        e.pc  = p;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        m     = mnemonic(w);
        if (m == "") begin
            e.illegal = 1'b1;
            return e;
        end
        e.op = 5'(op_of[m]);
        case (w[6:0])
            7'h33: begin
                e.rd_we = (e.rd != 0);
                e.chk_rs1 = 1'b1; e.chk_rs2 = 1'b1; e.chk_rd = 1'b1;
            end
            7'h13: begin
                e.use_imm = 1'b1;
                e.rd_we = (e.rd != 0);
                e.chk_rs1 = 1'b1; e.chk_rd = 1'b1; e.chk_imm = 1'b1;
                if (m == "SLLI" || m == "SRLI" || m == "SRAI") e.imm = (w >> 20) % 32;
                else if (m == "XORI") e.imm = 32'($signed(w) >>> 20);
                else e.imm = w >> 20;
            end
            7'h37, 7'h17: begin
                e.use_imm = 1'b1;
                e.use_pc = (m == "AUIPC");
                e.rd_we = (e.rd != 0);
                e.chk_rd = 1'b1; e.chk_imm = 1'b1;
                e.imm = w & 32'hFFFF_F000;
            end
            default: begin
                e.is_branch = 1'b1;
                e.chk_rs1 = 1'b1; e.chk_rs2 = 1'b1; e.chk_imm = 1'b1;
                off = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                e.imm = 32'(off);
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 6))
            0, 1: w[6:0] = 7'h33;
            2, 3: w[6:0] = 7'h13;
            4:    w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
            5:    w[6:0] = 7'h63;
            default: ;
        endcase
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        if ($urandom_range(0, 15) == 0) w = 32'h0;
        return w;
    endfunction

    // One clock of stimulus; the expected result is queued when the word is handed over.
    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p,
                         input logic ordy, input logic fl);
        exp_t e;
        @(negedge clk);
        in_valid = v; instr = w; pc = p; out_ready = ordy; flush = fl;
        #2;
        if (v && in_ready) begin
            e = ref_decode(w, p);
            if (e.illegal && model_cnt < 255) model_cnt++;
            if (!fl) exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; instr = 32'h0; flush = 1'b1; out_ready = 1'b0; pc = $urandom;
        repeat (2) @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; instr = '0; pc = '0;
        exp_q.delete();
        model_cnt = 0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_illegal_cnt", illegal_cnt, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_imm", imm, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_rd_we", rd_we, 0);
        chk("rst_rs1", rs1_idx, 0);
        chk("rst_use_imm", use_imm, 0);
        chk("rst_in_ready", in_ready, 1);
        mon_en = 1'b1;
    endtask

    // Monitor: compares the registered result against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                chk("out_valid", out_valid, exp_q.size() != 0);
                chk("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
                chk("illegal_cnt", illegal_cnt, model_cnt);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    if (out_valid) begin
                        chk("alu_op", alu_op, e.op);
                        chk("illegal", illegal, e.illegal);
                        chk("rd_we", rd_we, e.rd_we);
                        chk("out_pc", out_pc, e.pc);
                        if (!e.illegal) begin
                            chk("use_imm", use_imm, e.use_imm);
                            chk("use_pc", use_pc, e.use_pc);
                            chk("is_branch", is_branch, e.is_branch);
                        end
                        if (e.chk_rs1) chk("rs1_idx", rs1_idx, e.rs1);
                        if (e.chk_rs2) chk("rs2_idx", rs2_idx, e.rs2);
                        if (e.chk_rd)  chk("rd_idx", rd_idx, e.rd);
                        if (e.chk_imm) chk("imm", imm, e.imm);
                    end
                    if (out_ready || flush) begin
                        void'(exp_q.pop_front());
                        txn++;
                        $display("txn %0d: pc=%h alu_op=%0d illegal=%0b %s", txn, e.pc, e.op,
                                 e.illegal, (flush && !out_ready) ? "flushed" : "consumed");
                    end
                end
            end
        end
    end

    initial begin
        string names [21];
        names = '{"NOP", "ADD", "SUB", "SLL", "SRL", "SRA", "AND", "OR", "XOR", "SLT", "SLTU",
                  "ADDI", "SLLI", "SRLI", "SRAI", "ANDI", "ORI", "SLTI", "SLTIU", "LUI", "AUIPC"};
        foreach (names[i]) op_of[names[i]] = i;
        op_of["XORI"] = 8;
        op_of["BEQ"] = 2; op_of["BNE"] = 2; op_of["BLT"] = 2; op_of["BGE"] = 2;

        do_reset();

        // ADD x3,x1,x2
        drive(1, 32'h002081B3, 32'h100, 1, 0);
        drive(0, 32'h0, 32'h0, 0, 0);
        chk("add_valid", out_valid, 1);
        chk("add_op", alu_op, 1);
        chk("add_rs1", rs1_idx, 1);
        chk("add_rs2", rs2_idx, 2);
        chk("add_rd", rd_idx, 3);
        chk("add_rd_we", rd_we, 1);

        // Stall with a second word waiting, then release
        drive(0, 32'h0, 32'h0, 1, 0);
        drive(1, 32'h002081B3, 32'h200, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'hFFF00293, 32'h204, 0, 0);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_op", alu_op, 1);
            chk("stall_pc", out_pc, 32'h200);
        end
        drive(1, 32'hFFF00293, 32'h204, 1, 0);
        drive(0, 32'h0, 32'h0, 0, 0);
        chk("addi_op", alu_op, 11);
        chk("addi_imm", imm, 32'h0000_0FFF);
        chk("addi_use_imm", use_imm, 1);
        chk("addi_pc", out_pc, 32'h204);

        // XORI x5,x5,-1
        drive(1, 32'hFFF2C293, 32'h208, 1, 0);
        drive(0, 32'h0, 32'h0, 0, 0);
        chk("xori_op", alu_op, 8);
        chk("xori_imm", imm, 32'hFFFF_FFFF);
        chk("xori_use_imm", use_imm, 1);

        // LUI x1,0x12345 then AUIPC dropped by a coincident flush
        drive(1, 32'h123450B7, 32'h300, 1, 0);
        drive(0, 32'h0, 32'h0, 0, 0);
        chk("lui_op", alu_op, 19);
        chk("lui_imm", imm, 32'h1234_5000);
        chk("lui_use_pc", use_pc, 0);
        drive(1, 32'h12345097, 32'h304, 1, 1);
        drive(0, 32'h0, 32'h0, 0, 0);
        chk("flush_out_valid", out_valid, 0);
        drive(1, 32'h12345097, 32'h308, 1, 0);
        drive(0, 32'h0, 32'h0, 0, 0);
        chk("auipc_valid", out_valid, 1);
        chk("auipc_op", alu_op, 20);
        chk("auipc_use_pc", use_pc, 1);
        chk("auipc_imm", imm, 32'h1234_5000);
        chk("auipc_pc", out_pc, 32'h308);
        drive(0, 32'h0, 32'h0, 1, 0);

        // Saturation of the illegal counter
        for (int k = 0; k < 300; k++) drive(1, 32'h0, 32'(k * 4), 1, 0);
        drive(0, 32'h0, 32'h0, 1, 0);
        chk("illegal_cnt_sat", illegal_cnt, 255);
        do_reset();

        // Random traffic
        for (int k = 0; k < 800; k++)
            drive($urandom_range(0, 3) != 0, gen_instr(), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        repeat (3) drive(0, 32'h0, 32'h0, 1, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
